nibble_add_sequencer: RTL and testbench

Upstream operand sequencer for the team's 4-bit registered nibble adder (full_adder).
- Accepts a WIDTH-bit add request over a valid/ready handshake.
- Feeds the adder one nibble per step, LSB first, chaining the carry from each step into the next.
- Collects the SUM nibbles and returns a WIDTH-bit result plus carry-out over a second valid/ready handshake.
- The adder is instantiated beside this block, not inside it.

---
 rtl/nibble_seq_pkg.sv | 28 ++
 rtl/nibble_add_sequencer.sv | 176 +++++++++++++++++
 tb/tb_nibble_add_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_seq_pkg.sv
// -----------------------------------------------------------------------------
// nibble_seq_pkg
// Shared types and helpers for the nibble add sequencer.
//   NIB_W    : width of one adder step (a nibble)
//   MAX_W    : widest operand the nibble selector can take
//   state_e  : sequencer FSM states
//   nib_sel  : returns nibble number idx of a (zero-extended) vector
// -----------------------------------------------------------------------------
package nibble_seq_pkg;

    localparam int NIB_W = 4;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_e;

    // Shift rather than part-select so the nibble index needs no sizing.
    function automatic logic [NIB_W-1:0] nib_sel(input logic [MAX_W-1:0] vec,
                                                 input int unsigned       idx);
        logic [MAX_W-1:0] shifted_s;
        shifted_s = vec >> (NIB_W * idx);
        return shifted_s[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/nibble_add_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_add_sequencer
// Splits a WIDTH-bit add into NIBBLES steps on an external 4-bit registered
// adder, LSB nibble first, chaining the carry between steps, and returns the
// assembled sum plus carry-out.
//
// Ports
//   Clock, Reset_n          : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready       : request handshake; in_a, in_b, in_cin operands
//   add_a, add_b, add_cin   : nibble operands to the adder (0 outside STEP)
//   add_sum, add_cout       : adder results, valid ADDER_LAT cycles after inputs
//   out_valid/out_ready     : result handshake; out_sum, out_cout result
// -----------------------------------------------------------------------------
module nibble_add_sequencer
    import nibble_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDER_LAT = 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int WCNT_W  = ($clog2(ADDER_LAT + 1) > 0) ? $clog2(ADDER_LAT + 1) : 1;

    generate
        if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0) || (WIDTH > MAX_W)) begin : g_bad_width
            $error("nibble_add_sequencer: WIDTH must be a multiple of 4 in 4..64");
        end
        if (ADDER_LAT < 1) begin : g_bad_lat
            $error("nibble_add_sequencer: ADDER_LAT must be at least 1");
        end
    endgenerate

    state_e             state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_sum_r;
    logic               out_cout_r;
    logic [3:0]         add_a_r;
    logic [3:0]         add_b_r;
    logic               add_cin_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WCNT_W-1:0]  wcnt_r;

    logic [WIDTH-1:0]   res_next_s;
    logic [IDX_W-1:0]   idx_inc_s;
    logic               last_step_s;
    logic               sum_ready_s;

    // Result vector with the current adder nibble merged in, plus step control.
    always_comb begin
        res_next_s  = res_r;
        idx_inc_s   = idx_r + 1'b1;
        last_step_s = (idx_r == IDX_W'(NIBBLES - 1));
        sum_ready_s = (wcnt_r == WCNT_W'(ADDER_LAT));
        if (state_r == STEP) begin
            res_next_s = (res_r & ~(WIDTH'(4'hF) << (NIB_W * idx_r)))
                       | (WIDTH'(add_sum) << (NIB_W * idx_r));
        end else begin
            res_next_s = res_r;
        end
    end

    // Sequencer FSM with all outputs registered; adder operands for the next
    // step are loaded on the same edge that retires the current one, so they
    // are valid from the first cycle of every step.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_cout_r  <= 1'b0;
            add_a_r     <= 4'h0;
            add_b_r     <= 4'h0;
            add_cin_r   <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            res_r       <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            wcnt_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_ready_r && in_valid) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        carry_r    <= in_cin;
                        res_r      <= '0;
                        idx_r      <= '0;
                        wcnt_r     <= '0;
                        in_ready_r <= 1'b0;
                        add_a_r    <= nib_sel(MAX_W'(in_a), 32'd0);
                        add_b_r    <= nib_sel(MAX_W'(in_b), 32'd0);
                        add_cin_r  <= in_cin;
                        state_r    <= STEP;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                STEP: begin
                    if (sum_ready_s) begin
                        res_r   <= res_next_s;
                        carry_r <= add_cout;
                        wcnt_r  <= '0;
                        if (last_step_s) begin
                            idx_r       <= '0;
                            out_sum_r   <= res_next_s;
                            out_cout_r  <= add_cout;
                            out_valid_r <= 1'b1;
                            add_a_r     <= 4'h0;
                            add_b_r     <= 4'h0;
                            add_cin_r   <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            idx_r     <= idx_inc_s;
                            add_a_r   <= nib_sel(MAX_W'(a_r), 32'(idx_inc_s));
                            add_b_r   <= nib_sel(MAX_W'(b_r), 32'(idx_inc_s));
                            add_cin_r <= add_cout;
                        end
                    end else begin
                        wcnt_r <= wcnt_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    add_a_r     <= 4'h0;
                    add_b_r     <= 4'h0;
                    add_cin_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_cin   = add_cin_r;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_sequencer
// Two sequencer instances (ADDER_LAT=1 and ADDER_LAT=2), each wired to a
// behavioural registered nibble adder of matching latency. Expected results
// go into a queue when a request is driven and are popped when out_valid
// is seen.
// -----------------------------------------------------------------------------
module tb_nibble_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [16:0] sb[$];

    // Instance 1: default parameters.
    logic        in_valid = 1'b0, in_ready, in_cin = 1'b0;
    logic [15:0] in_a = 16'h0, in_b = 16'h0, out_sum;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout, out_valid, out_cout;
    logic        out_ready = 1'b0;
    logic [4:0]  ad1_q = 5'd0;

    // Instance 2: ADDER_LAT = 2.
    logic        d2_in_valid = 1'b0, d2_in_ready, d2_in_cin = 1'b0;
    logic [15:0] d2_in_a = 16'h0, d2_in_b = 16'h0, d2_out_sum;
    logic [3:0]  d2_add_a, d2_add_b, d2_add_sum;
    logic        d2_add_cin, d2_add_cout, d2_out_valid, d2_out_cout;
    logic        d2_out_ready = 1'b0;
    logic [4:0]  ad2_q1 = 5'd0, ad2_q2 = 5'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered nibble adder models.
    always @(posedge clk) begin
        ad1_q  <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
        ad2_q1 <= {1'b0, d2_add_a} + {1'b0, d2_add_b} + {4'b0, d2_add_cin};
        ad2_q2 <= ad2_q1;
    end
    assign add_sum     = ad1_q[3:0];
    assign add_cout    = ad1_q[4];
    assign d2_add_sum  = ad2_q2[3:0];
    assign d2_add_cout = ad2_q2[4];

    nibble_add_sequencer #(.WIDTH(16), .ADDER_LAT(1)) dut (
        .Clock(clk), .Reset_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    nibble_add_sequencer #(.WIDTH(16), .ADDER_LAT(2)) dut2 (
        .Clock(clk), .Reset_n(rst_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_a(d2_in_a), .in_b(d2_in_b), .in_cin(d2_in_cin),
        .add_a(d2_add_a), .add_b(d2_add_b), .add_cin(d2_add_cin),
        .add_sum(d2_add_sum), .add_cout(d2_add_cout),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_sum(d2_out_sum), .out_cout(d2_out_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0 || out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h cout=%b, expected 0 0 0000 0",
                     in_ready, out_valid, out_sum, out_cout);
        end
        n_checks++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0 || d2_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_adder_if: got a=%h b=%h cin=%b rdy2=%b, expected 0 0 0 0",
                     add_a, add_b, add_cin, d2_in_ready);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || d2_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b/%b, expected 1/1", in_ready, d2_in_ready);
        end
    endtask

    // One request on instance 1; checks per-step operands and carry-in,
    // latency, and the scoreboard result. consume=1 also completes the
    // output handshake.
    task automatic run_req(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input bit consume);
        logic [3:0]  cins;
        logic        c;
        logic [4:0]  s5;
        logic [16:0] exp_v;
        int          t0;
        int          step;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            cins[i] = c;
            s5 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            c  = s5[4];
        end
        for (int k = 0; k < 20 && in_ready !== 1'b1; k++) tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: got in_ready=%b, expected 1", name, in_ready);
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        t0 = cyc;
        sb.push_back({1'b0, a} + {1'b0, b} + {16'b0, cin});
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && out_valid !== 1'b1; k++) begin
            step = (cyc - t0 - 1) / 2;
            if (((cyc - t0 - 1) % 2) == 0 && step < 4) begin
                n_checks++;
                if (add_cin !== cins[step] || add_a !== a[4*step +: 4] || add_b !== b[4*step +: 4]) begin
                    n_fail++;
                    $display("FAIL %s_step%0d: got a=%h b=%h cin=%b, expected a=%h b=%h cin=%b",
                             name, step, add_a, add_b, add_cin, a[4*step +: 4], b[4*step +: 4], cins[step]);
                end
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b1 || (cyc - t0) != 9) begin
            n_fail++;
            $display("FAIL %s_latency: got out_valid=%b at T+%0d, expected 1 at T+9",
                     name, out_valid, cyc - t0);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue, expected one entry", name);
        end else begin
            exp_v = sb.pop_front();
            if ({out_cout, out_sum} !== exp_v) begin
                n_fail++;
                $display("FAIL %s_result: got cout=%b sum=%h, expected cout=%b sum=%h",
                         name, out_cout, out_sum, exp_v[16], exp_v[15:0]);
            end
        end
        if (consume) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_handshake: got vld=%b rdy=%b, expected 0 1", name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_basic();
        run_req("add_1_1", 16'h0001, 16'h0001, 1'b0, 1'b1);
        run_req("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        run_req("add_1234_4321", 16'h1234, 16'h4321, 1'b1, 1'b0);
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== 16'h5556 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got vld=%b sum=%h cout=%b rdy=%b, expected 1 5556 0 0",
                         k, out_valid, out_sum, out_cout, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || add_a !== 4'h0) begin
            n_fail++;
            $display("FAIL no_second_accept: got rdy=%b add_a=%h, expected 1 0", in_ready, add_a);
        end
    endtask

    task automatic test_mid_reset();
        int t0;
        in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0;
        t0 = cyc;
        sb.push_back({1'b0, 16'hAAAA} + {1'b0, 16'h5555});
        tick();
        in_valid = 1'b0;
        while (cyc < t0 + 5) tick();
        n_checks++;
        if (add_a !== 4'hA || add_b !== 4'h5) begin
            n_fail++;
            $display("FAIL midrst_step2: got a=%h b=%h, expected a=a b=5", add_a, add_b);
        end
        rst_n = 1'b0;
        tick();
        sb.delete();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || add_a !== 4'h0 || add_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_edge: got vld=%b rdy=%b a=%h cin=%b, expected 0 0 0 0",
                     out_valid, in_ready, add_a, add_cin);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_recover: got rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
        end
        run_req("add_00ff_1", 16'h00FF, 16'h0001, 1'b0, 1'b1);
    endtask

    task automatic test_lat2();
        logic [15:0] a, b;
        logic [16:0] exp_v;
        int          t0;
        int          step;
        a = 16'h8F0F; b = 16'h70F1;
        for (int k = 0; k < 20 && d2_in_ready !== 1'b1; k++) tick();
        d2_in_valid = 1'b1; d2_in_a = a; d2_in_b = b; d2_in_cin = 1'b0;
        t0 = cyc;
        sb.push_back({1'b0, a} + {1'b0, b});
        tick();
        d2_in_valid = 1'b0;
        for (int k = 0; k < 60 && d2_out_valid !== 1'b1; k++) begin
            step = (cyc - t0 - 1) / 3;
            if (step < 4) begin
                n_checks++;
                if (d2_add_a !== a[4*step +: 4] || d2_add_b !== b[4*step +: 4]) begin
                    n_fail++;
                    $display("FAIL lat2_hold_T+%0d: got a=%h b=%h, expected a=%h b=%h",
                             cyc - t0, d2_add_a, d2_add_b, a[4*step +: 4], b[4*step +: 4]);
                end
            end
            tick();
        end
        n_checks++;
        if (d2_out_valid !== 1'b1 || (cyc - t0) != 13) begin
            n_fail++;
            $display("FAIL lat2_latency: got out_valid=%b at T+%0d, expected 1 at T+13",
                     d2_out_valid, cyc - t0);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL lat2_scoreboard: got empty queue, expected one entry");
        end else begin
            exp_v = sb.pop_front();
            if ({d2_out_cout, d2_out_sum} !== exp_v) begin
                n_fail++;
                $display("FAIL lat2_result: got cout=%b sum=%h, expected cout=%b sum=%h",
                         d2_out_cout, d2_out_sum, exp_v[16], exp_v[15:0]);
            end
        end
        d2_out_ready = 1'b1;
        tick();
        d2_out_ready = 1'b0;
        n_checks++;
        if (d2_out_valid !== 1'b0 || d2_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat2_handshake: got vld=%b rdy=%b, expected 0 1", d2_out_valid, d2_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_mid_reset();
        test_lat2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
